// File: rtl/swp_pkg.sv
// Shared types and constants for the swp_tx serial transmitter.
// An 18-bit word leaves the block as three 8N1 characters, low byte first.
package swp_pkg;

    localparam int         WIDTH = 18;
    localparam int         BYTES = 3;
    localparam logic [5:0] PAD   = 6'b0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // Character idx of a word; the last character carries the two top bits.
    function automatic logic [7:0] byte_sel(input logic [WIDTH-1:0] word,
                                            input logic [1:0]       idx);
        case (idx)
            2'd0:    return word[7:0];
            2'd1:    return word[15:8];
            default: return {PAD, word[17:16]};
        endcase
    endfunction

endpackage

// File: rtl/swp_tx_if.sv
// Processor-side handshake of swp_tx: word, strobe, global enable, serial line and status.
interface swp_tx_if;
    import swp_pkg::*;

    logic             en;
    logic             start;
    logic [WIDTH-1:0] din;
    logic             tx;
    logic             busy;
    logic             done;

    modport master (output en, start, din, input tx, busy, done);
    modport slave  (input en, start, din, output tx, busy, done);

endinterface

// File: rtl/swp_baud.sv
// Modulo-CLKS_PER_BIT bit-period counter; tick marks the wrap cycle.
// Frozen with the rest of the datapath while en is low.
module swp_baud #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int            CW   = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of process ordering.
    always_ff @(negedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (en) begin
            if (clr || cnt == LAST)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/swp_tx.sv
// 18-bit word to three 8N1 characters; registered tx/busy/done, falling-edge datapath.
// Acceptance drives the start bit on the same edge, so first-bit latency is zero.
module swp_tx
    import swp_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic     clk,
    input  logic     rst,
    swp_tx_if.slave  bus
);

    state_t           state, state_nxt;
    logic [2:0]       bit_idx, bit_nxt;
    logic [1:0]       byte_idx, byte_nxt;
    logic [WIDTH-1:0] word;
    logic             tx_q, busy_q, done_q;
    logic             tx_nxt, busy_nxt, done_nxt;
    logic [7:0]       cur_byte;
    logic             tick;

    // Holding the counter clear in IDLE makes it start from 0 on acceptance.
    swp_baud #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk  (clk),
        .rst  (rst),
        .en   (bus.en),
        .clr  (state == IDLE),
        .tick (tick)
    );

    assign bus.tx   = tx_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

    always_ff @(negedge clk) begin
        if (rst) begin
            state    <= IDLE;
            bit_idx  <= '0;
            byte_idx <= '0;
            word     <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else if (bus.en) begin
            state    <= state_nxt;
            bit_idx  <= bit_nxt;
            byte_idx <= byte_nxt;
            if (state == IDLE && bus.start)
                word <= bus.din;
            tx_q     <= tx_nxt;
            busy_q   <= busy_nxt;
            done_q   <= done_nxt;
        end
    end

    // NOTE: each combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        bit_nxt   = bit_idx;
        byte_nxt  = byte_idx;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = START;
                    bit_nxt   = '0;
                    byte_nxt  = '0;
                end
            end
            START: begin
                if (tick) begin
                    state_nxt = DATA;
                    bit_nxt   = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_idx == 3'd7)
                        state_nxt = STOP;
                    else
                        bit_nxt = bit_idx + 3'd1;
                end
            end
            STOP: begin
                if (tick) begin
                    if (byte_idx < 2'(BYTES - 1)) begin
                        state_nxt = START;
                        byte_nxt  = byte_idx + 2'd1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are computed from the next state so they register on the transition edge.
    always_comb begin
        cur_byte = byte_sel(word, byte_nxt);
        tx_nxt   = 1'b1;
        busy_nxt = (state_nxt != IDLE);
        done_nxt = (state == STOP) && tick && (byte_idx == 2'(BYTES - 1));
        case (state_nxt)
            START:   tx_nxt = 1'b0;
            DATA:    tx_nxt = cur_byte[bit_nxt];
            default: tx_nxt = 1'b1;
        endcase
    end

endmodule
